inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter cResetPc, default 32'h0000_0000, PC fetched first after reset.
REQ-002 SHALL have parameter cFifoDepth, default 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port iClk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port iRst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port oImemReq  output  1  instruction memory read request.
REQ-006 SHALL have port oImemAddr  output  cXLEN  byte address of request, bits [1:0] always 0.
REQ-007 SHALL have port iImemGnt  input  1  memory accepts request this cycle (oImemReq & iImemGnt = issue).
REQ-008 SHALL have port iImemValid  input  1  read data valid, exactly one cycle after the issuing cycle.
REQ-009 SHALL have port iImemData  input  cXLEN  instruction word returned.
REQ-010 SHALL have port iStall  input  1  decoder cannot accept this cycle.
REQ-011 SHALL have port iFlush  input  1  redirect (taken branch/jump), single-cycle pulse.
REQ-012 SHALL have port iFlushPc  input  cXLEN  redirect target; bits [1:0] ignored, treated as 0.
REQ-013 SHALL have port oInst  output  cXLEN  instruction to decoder (feeds iInst).
REQ-014 SHALL have port oCurPc  output  cXLEN  PC of oInst (feeds iCurPc).
REQ-015 SHALL have port oValid  output  1  oInst/oCurPc hold a real fetched instruction.

Function
REQ-016 SHALL keep fetch PC register fPc; fPc advances by 4 on every issue, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-017 SHALL drive oImemAddr = fPc combinationally.
REQ-018 SHALL implement states eBoot, eRun, eDrop; eBoot -> eRun after one cycle; eRun -> eDrop on iFlush; eDrop -> eRun after one cycle (eDrop -> eDrop if iFlush again).
REQ-019 SHALL hold oImemReq = 0 in eBoot and in any cycle with iFlush = 1.
REQ-020 SHALL assert oImemReq in eRun/eDrop when (fifoCount + inFlight - pop) < cFifoDepth; pop = oValid & ~iStall; inFlight = issue in previous cycle.
REQ-021 SHALL push {iImemData, issuing PC} into the FIFO when iImemValid = 1, unless the response is discarded.
REQ-022 SHALL discard any response arriving in the cycle after an iFlush (state eDrop, or iFlush in eDrop) issued before the flush; responses to requests issued in eDrop are kept.
REQ-023 SHALL present FIFO head on oInst/oCurPc with oValid = 1 when FIFO non-empty; pop on oValid & ~iStall.
REQ-024 SHALL drive oInst = 32'h0000_0013 (NOP), oCurPc = 0, oValid = 0 when FIFO empty.
REQ-025 SHALL on iFlush: empty FIFO (oValid = 0 next cycle), load fPc <= {iFlushPc[31:2],2'b00}, ignore pop and push that cycle.
REQ-026 SHALL give iFlush priority over iStall, pop, push and issue in the same cycle.
REQ-027 SHALL support simultaneous push and pop with count unchanged; push into full FIFO SHALL not occur by construction (REQ-020).
REQ-028 SHALL achieve one instruction per cycle steady state with iGnt = 1 and iStall = 0; latency fetch-issue to oValid = 2 cycles.
REQ-029 SHALL hold oInst/oCurPc/oValid stable while iStall = 1 and no flush.

Reset
REQ-030 SHALL, while iRst = 0, asynchronously force: state eBoot, fPc = cResetPc, FIFO empty, inFlight = 0, oImemReq = 0, oValid = 0, oInst = 32'h0000_0013, oCurPc = 0.
REQ-031 SHALL discard a response whose request was issued before a reset assertion mid-operation.
REQ-032 SHALL issue first request (addr cResetPc) in the second cycle after iRst deassertion.

Verification
REQ-033 Reset release, iGnt = 1, iStall = 0, memory returns addr-tagged words -> issues 0x0,0x4,0x8...; oValid rises 2 cycles after first issue, oCurPc 0x0,0x4,0x8 on consecutive cycles.
REQ-034 iStall = 1 for 5 cycles in steady state -> oInst/oCurPc held, exactly cFifoDepth entries buffered, oImemReq drops, no instruction lost or duplicated after release.
REQ-035 iFlush with iFlushPc = 32'h0000_0103 while a request is in flight -> old response dropped, next issue addr 0x100, first valid oCurPc 0x100.
REQ-036 cResetPc = 32'hFFFF_FFF8, free-running -> issue addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
REQ-037 iGnt toggling 1/0 each cycle -> addresses strictly sequential, no address issued twice, oValid on alternate cycles.
REQ-038 iRst asserted mid-stream with FIFO full -> all outputs at reset values immediately (asynchronously), restart at cResetPc.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response plus the decoder-side
// instruction stream and redirect inputs. The master modport is the fetch unit.
interface inst_fetch_if #(
  parameter int cXLEN = 32
);
  logic             oImemReq;
  logic [cXLEN-1:0] oImemAddr;
  logic             iImemGnt;
  logic             iImemValid;
  logic [cXLEN-1:0] iImemData;
  logic             iStall;
  logic             iFlush;
  logic [cXLEN-1:0] iFlushPc;
  logic [cXLEN-1:0] oInst;
  logic [cXLEN-1:0] oCurPc;
  logic             oValid;

  modport master (
    output oImemReq, oImemAddr, oInst, oCurPc, oValid,
    input  iImemGnt, iImemValid, iImemData, iStall, iFlush, iFlushPc
  );

  modport slave (
    input  oImemReq, oImemAddr, oInst, oCurPc, oValid,
    output iImemGnt, iImemValid, iImemData, iStall, iFlush, iFlushPc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues sequential word fetches, buffers returned words in a
// small FIFO and streams {instruction, PC} to the decoder; redirects on flush.
module inst_fetch #(
  parameter logic [31:0] cResetPc   = 32'h0000_0000,
  parameter int          cFifoDepth = 2
) (
  input  logic         iClk,
  input  logic         iRst,
  inst_fetch_if.master bus
);
  localparam int               cPtrW   = $clog2(cFifoDepth);
  localparam int               cCntW   = cPtrW + 1;
  localparam logic [cCntW:0]   cDepthV = (cCntW + 1)'(cFifoDepth);
  localparam logic [31:0]      cNop    = 32'h0000_0013;
  localparam logic [31:0]      cBootPc = {cResetPc[31:2], 2'b00};

  typedef enum logic [1:0] {
    eBoot = 2'd0,
    eRun  = 2'd1,
    eDrop = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_fpc;
  logic [31:0]       r_inflight_pc;
  logic              r_inflight;
  logic [cPtrW-1:0]  r_wr_ptr;
  logic [cPtrW-1:0]  r_rd_ptr;
  logic [cCntW-1:0]  r_count;
  logic [31:0]       r_inst_mem [cFifoDepth];
  logic [31:0]       r_pc_mem   [cFifoDepth];

  logic              w_nonempty;
  logic              w_pop;
  logic              w_push;
  logic              w_req;
  logic              w_issue;
  logic [cCntW:0]    w_occ;
  logic              w_unused;

  assign w_nonempty = (r_count != {cCntW{1'b0}});
  assign w_pop      = w_nonempty & ~bus.iStall & ~bus.iFlush;
  // Occupancy counts the word already in flight so a full FIFO is never overrun.
  assign w_occ      = {1'b0, r_count} + {{cCntW{1'b0}}, r_inflight} - {{cCntW{1'b0}}, w_pop};
  assign w_req      = (r_state != eBoot) & ~bus.iFlush & (w_occ < cDepthV);
  assign w_issue    = w_req & bus.iImemGnt;
  // A response is kept only if its request is still owned (not killed by flush or reset).
  assign w_push     = bus.iImemValid & r_inflight & ~bus.iFlush;
  assign w_unused   = &{1'b0, bus.iFlushPc[1:0]};

  assign bus.oImemReq  = w_req;
  assign bus.oImemAddr = r_fpc;
  assign bus.oValid    = w_nonempty;
  assign bus.oInst     = w_nonempty ? r_inst_mem[r_rd_ptr] : cNop;
  assign bus.oCurPc    = w_nonempty ? r_pc_mem[r_rd_ptr]   : 32'h0000_0000;

  // Sequencing state: one idle cycle after reset, eDrop marks the cycle after a redirect.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= eBoot;
    end else begin
      case (r_state)
        eBoot:   r_state <= eRun;
        eRun:    r_state <= bus.iFlush ? eDrop : eRun;
        eDrop:   r_state <= bus.iFlush ? eDrop : eRun;
        default: r_state <= eBoot;
      endcase
    end
  end

  // Fetch PC and the tag of the single outstanding request.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_fpc         <= cBootPc;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
    end else if (bus.iFlush) begin
      r_fpc         <= {bus.iFlushPc[31:2], 2'b00};
      r_inflight    <= 1'b0;
      r_inflight_pc <= r_inflight_pc;
    end else begin
      r_inflight    <= w_issue;
      r_inflight_pc <= r_fpc;
      if (w_issue) begin
        r_fpc <= r_fpc + 32'd4;
      end else begin
        r_fpc <= r_fpc;
      end
    end
  end

  // FIFO pointers and occupancy; a flush empties the buffer outright.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_wr_ptr <= {cPtrW{1'b0}};
      r_rd_ptr <= {cPtrW{1'b0}};
      r_count  <= {cCntW{1'b0}};
    end else if (bus.iFlush) begin
      r_wr_ptr <= {cPtrW{1'b0}};
      r_rd_ptr <= {cPtrW{1'b0}};
      r_count  <= {cCntW{1'b0}};
    end else begin
      r_wr_ptr <= r_wr_ptr + cPtrW'(w_push);
      r_rd_ptr <= r_rd_ptr + cPtrW'(w_pop);
      r_count  <= r_count + cCntW'(w_push) - cCntW'(w_pop);
    end
  end

  // FIFO storage; contents are only observed through a non-zero count.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= bus.iImemData;
      r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: queue-based reference model driven by
// randomized and directed scenarios, plus a wrap-around check on a second instance.
module tb_inst_fetch;
  localparam logic [31:0] cPc0    = 32'h0000_0000;
  localparam int          cDepth0 = 2;
  localparam logic [31:0] cPc1    = 32'hFFFF_FFF8;
  localparam int          cDepth1 = 4;
  localparam logic [31:0] cNop    = 32'h0000_0013;
  localparam logic [97:0] cRstVec = {1'b0, cPc0, 1'b0, cNop, 32'h0000_0000};

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst1_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_if if0 ();
  inst_fetch_if if1 ();

  inst_fetch #(.cResetPc(cPc0), .cFifoDepth(cDepth0)) dut0 (.iClk(clk), .iRst(rst_n),  .bus(if0));
  inst_fetch #(.cResetPc(cPc1), .cFifoDepth(cDepth1)) dut1 (.iClk(clk), .iRst(rst1_n), .bus(if1));

  logic [97:0] obs0;
  assign obs0 = {if0.oImemReq, if0.oImemAddr, if0.oValid, if0.oInst, if0.oCurPc};

  // reference model state: buffered {inst, pc}, fetch pc, outstanding request
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic        m_if;
  logic        m_boot;
  logic        mem_v;
  logic [31:0] mem_a;
  logic [97:0] exp_vec;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C00_0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = cPc0;
    m_if   = 1'b0;
    m_ifpc = 32'h0000_0000;
    m_boot = 1'b0;
  endtask

  task automatic release0();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // drive one cycle on dut0, compute the expected outputs for it, advance the model
  task automatic step(input logic s, input logic f, input logic g, input logic [31:0] fpc);
    logic        pop, req, val, drove_v;
    logic [31:0] old_pc;
    @(negedge clk);
    drove_v        = mem_v;
    if0.iStall     = s;
    if0.iFlush     = f;
    if0.iFlushPc   = fpc;
    if0.iImemGnt   = g;
    if0.iImemValid = mem_v;
    if0.iImemData  = mem_v ? tag(mem_a) : $urandom();
    #1;
    val = (mq.size() != 0);
    pop = val & ~s;
    req = m_boot & ~f & ((mq.size() + int'(m_if) - int'(pop)) < cDepth0);
    if (val) exp_vec = {req, m_pc, 1'b1, mq[0][63:32], mq[0][31:0]};
    else     exp_vec = {req, m_pc, 1'b0, cNop, 32'h0000_0000};
    mem_v = if0.oImemReq & g;
    mem_a = if0.oImemAddr;
    if (f) begin
      mq.delete();
      m_pc = {fpc[31:2], 2'b00};
      m_if = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (drove_v && m_if) mq.push_back({tag(m_ifpc), m_ifpc});
      old_pc = m_pc;
      if (req && g) m_pc = m_pc + 32'd4;
      m_if   = req & g;
      m_ifpc = old_pc;
    end
    m_boot = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (obs0 !== cRstVec) begin
      n_bad++; $display("FAIL reset_dut0 got=%h want=%h", obs0, cRstVec);
    end
    n_total++;
    if ({if1.oImemReq, if1.oImemAddr, if1.oValid} !== {1'b0, cPc1, 1'b0}) begin
      n_bad++; $display("FAIL reset_dut1 got=%h want=%h", {if1.oImemReq, if1.oImemAddr, if1.oValid}, {1'b0, cPc1, 1'b0});
    end
    model_reset();
    release0();
  endtask

  task automatic test_stream();
    int first_iss = -1;
    int first_val = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL stream c%0d got=%h want=%h", i, obs0, exp_vec);
      end
      if (first_iss < 0 && if0.oImemReq) first_iss = i;
      if (first_val < 0 && if0.oValid)   first_val = i;
    end
    n_total++;
    if (first_iss !== 1) begin
      n_bad++; $display("FAIL stream_first_issue got=%0d want=1", first_iss);
    end
    n_total++;
    if (first_val - first_iss !== 2) begin
      n_bad++; $display("FAIL stream_latency got=%0d want=2", first_val - first_iss);
    end
  endtask

  task automatic test_stall();
    logic [31:0] last = 32'h0;
    logic        have = 1'b0;
    logic        s;
    for (int i = 0; i < 20; i++) begin
      s = (i >= 3 && i < 8);
      step(s, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL stall c%0d got=%h want=%h", i, obs0, exp_vec);
      end
      if (i == 7) begin
        n_total++;
        if (if0.oImemReq !== 1'b0 || if0.oValid !== 1'b1) begin
          n_bad++; $display("FAIL stall_full got req=%b valid=%b want req=0 valid=1", if0.oImemReq, if0.oValid);
        end
      end
      if (if0.oValid && !s) begin
        if (have) begin
          n_total++;
          if (if0.oCurPc !== last + 32'd4) begin
            n_bad++; $display("FAIL stall_seq got=%h want=%h", if0.oCurPc, last + 32'd4);
          end
        end
        last = if0.oCurPc;
        have = 1'b1;
      end
    end
  endtask

  task automatic test_flush();
    logic found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL flush_pre c%0d got=%h want=%h", i, obs0, exp_vec);
      end
    end
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    n_total++;
    if (obs0 !== exp_vec) begin
      n_bad++; $display("FAIL flush_cyc got=%h want=%h", obs0, exp_vec);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    n_total++;
    if (if0.oImemReq !== 1'b1 || if0.oImemAddr !== 32'h0000_0100 || if0.oValid !== 1'b0) begin
      n_bad++; $display("FAIL flush_redirect got req=%b addr=%h valid=%b want 1 00000100 0", if0.oImemReq, if0.oImemAddr, if0.oValid);
    end
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL flush_post c%0d got=%h want=%h", i, obs0, exp_vec);
      end
      if (if0.oValid) begin
        found = 1'b1;
        n_total++;
        if (if0.oCurPc !== 32'h0000_0100) begin
          n_bad++; $display("FAIL flush_first_pc got=%h want=00000100", if0.oCurPc);
        end
      end
    end
    if (!found) begin
      n_total++; n_bad++;
      $display("FAIL flush_timeout got no valid want valid within 8 cycles");
    end
  endtask

  task automatic test_gnt_toggle();
    logic [31:0] last_a = 32'h0;
    logic        have   = 1'b0;
    logic        g;
    for (int i = 0; i < 16; i++) begin
      g = ((i % 2) == 0);
      step(1'b0, 1'b0, g, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL gnt c%0d got=%h want=%h", i, obs0, exp_vec);
      end
      if (if0.oImemReq && g) begin
        if (have) begin
          n_total++;
          if (if0.oImemAddr !== last_a + 32'd4) begin
            n_bad++; $display("FAIL gnt_seq got=%h want=%h", if0.oImemAddr, last_a + 32'd4);
          end
        end
        last_a = if0.oImemAddr;
        have   = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    logic s, f, g;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 3);
      f = ($urandom_range(0, 19) == 0);
      g = ($urandom_range(0, 9) < 7);
      step(s, f, g, $urandom());
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL random c%0d s=%b f=%b g=%b got=%h want=%h", i, s, f, g, obs0, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL rstmid_fill c%0d got=%h want=%h", i, obs0, exp_vec);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (obs0 !== cRstVec) begin
      n_bad++; $display("FAIL rstmid_async got=%h want=%h", obs0, cRstVec);
    end
    model_reset();
    mem_v = 1'b0;
    release0();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL rstmid_restart c%0d got=%h want=%h", i, obs0, exp_vec);
      end
      if (i == 1) begin
        n_total++;
        if (if0.oImemReq !== 1'b1 || if0.oImemAddr !== cPc0) begin
          n_bad++; $display("FAIL rstmid_first got req=%b addr=%h want 1 %h", if0.oImemReq, if0.oImemAddr, cPc0);
        end
      end
    end
  endtask

  task automatic test_stale();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL stale_pre c%0d got=%h want=%h", i, obs0, exp_vec);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (obs0 !== cRstVec) begin
      n_bad++; $display("FAIL stale_reset got=%h want=%h", obs0, cRstVec);
    end
    #1 rst_n = 1'b1;
    model_reset();
    m_boot = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      n_total++;
      if (obs0 !== exp_vec) begin
        n_bad++; $display("FAIL stale_post c%0d got=%h want=%h", i, obs0, exp_vec);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] iss [$];
    logic [31:0] cur [$];
    logic [31:0] exp_a [4];
    logic        v1 = 1'b0;
    logic [31:0] a1 = 32'h0;
    int          first_iss = -1;
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    @(posedge clk);
    #2 rst1_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if1.iImemValid = v1;
      if1.iImemData  = tag(a1);
      #1;
      if (if1.oImemReq) begin
        iss.push_back(if1.oImemAddr);
        if (first_iss < 0) first_iss = i;
      end
      if (if1.oValid) begin
        cur.push_back(if1.oCurPc);
        n_total++;
        if (if1.oInst !== tag(if1.oCurPc)) begin
          n_bad++; $display("FAIL wrap_inst got=%h want=%h", if1.oInst, tag(if1.oCurPc));
        end
      end
      v1 = if1.oImemReq;
      a1 = if1.oImemAddr;
    end
    n_total++;
    if (first_iss !== 1) begin
      n_bad++; $display("FAIL wrap_first_issue got=%0d want=1", first_iss);
    end
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (iss.size() <= k) begin
        n_bad++; $display("FAIL wrap_addr%0d got=none want=%h", k, exp_a[k]);
      end else if (iss[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL wrap_addr%0d got=%h want=%h", k, iss[k], exp_a[k]);
      end
      n_total++;
      if (cur.size() <= k) begin
        n_bad++; $display("FAIL wrap_pc%0d got=none want=%h", k, exp_a[k]);
      end else if (cur[k] !== exp_a[k]) begin
        n_bad++; $display("FAIL wrap_pc%0d got=%h want=%h", k, cur[k], exp_a[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.iStall = 1'b0; if0.iFlush = 1'b0; if0.iFlushPc = 32'h0; if0.iImemGnt = 1'b0;
    if0.iImemValid = 1'b0; if0.iImemData = 32'h0;
    if1.iStall = 1'b0; if1.iFlush = 1'b0; if1.iFlushPc = 32'h0; if1.iImemGnt = 1'b1;
    if1.iImemValid = 1'b0; if1.iImemData = 32'h0;
    mem_v = 1'b0;
    mem_a = 32'h0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_gnt_toggle();
    test_random();
    test_reset_mid();
    test_stale();
    test_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
